// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: serial receive front end of the APB UART.
// Oversamples the rx line at OVERSAMPLE x baud, validates the start bit at
// its midpoint, shifts in 5..8 data bits LSB-first, checks parity and the
// first stop bit, and pushes each completed character into the RX FIFO with
// per-character parity / framing / break / overrun pulses.
// Optional feature macro: RX_TIMEOUT_EN (adds the idle-line character timeout).
module uart_rx_deserializer #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       baud_tick_i,
   input  logic       rx_i,
   input  logic [1:0] cfg_data_bits_i,
   input  logic       cfg_parity_en_i,
   input  logic       cfg_parity_even_i,
   input  logic       cfg_parity_stick_i,
   input  logic       fifo_rx_full_i,
`ifdef RX_TIMEOUT_EN
   input  logic       fifo_rx_empty_i,
   input  logic       fifo_rx_pop_i,
   output logic       rx_timeout_o,
`endif
   output logic [7:0] fifo_rx_o,
   output logic       fifo_rx_push_o,
   output logic       rx_parity_err_o,
   output logic       rx_frame_err_o,
   output logic       rx_break_o,
   output logic       rx_overrun_o,
   output logic       rx_busy_o
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   typedef struct packed {
      logic [1:0] data_bits;
      logic       par_en;
      logic       par_even;
      logic       par_stick;
   } frame_cfg_t;

   state_t             state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic               rx_s;
   logic               armed_q;
   logic [OS_W-1:0]    os_cnt_q;
   logic [2:0]         bit_cnt_q;
   logic [7:0]         data_q;
   frame_cfg_t         cfg_q;
   logic               par_err_q;
   logic               all_zero_q;

   logic start_det, mid_start, bit_end, last_bit, char_done, par_err_now;

   // Metastability synchroniser; idles high so reset does not fake a start bit.
   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '1;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
   end

   assign rx_s      = sync_q[SYNC_STAGES-1];
   assign mid_start = baud_tick_i && (os_cnt_q == OS_HALF);
   assign bit_end   = baud_tick_i && (os_cnt_q == OS_LAST);
   // bit_cnt reaches N-1 = 4 + data_bits on the last data bit.
   assign last_bit  = (bit_cnt_q == {1'b1, cfg_q.data_bits});

   // Parity check on the sampled parity bit against the latched frame config.
   always_comb begin
      par_err_now = 1'b0;
      if (cfg_q.par_stick)     par_err_now = (rx_s != ~cfg_q.par_even);
      else if (cfg_q.par_even) par_err_now = ((^data_q) ^ rx_s) != 1'b0;
      else                     par_err_now = ((^data_q) ^ rx_s) != 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic and frame events.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      start_det = 1'b0;
      char_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (baud_tick_i && armed_q && !rx_s) begin
               state_d   = START;
               start_det = 1'b1;
            end
         end
         START: begin
            if (mid_start) state_d = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (bit_end && last_bit) state_d = cfg_q.par_en ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            // Resync at mid-stop so the next start edge is caught early.
            if (bit_end) begin
               state_d   = IDLE;
               char_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Receive datapath: counters, shift register, arm flag and frame config.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed_q    <= 1'b0;
         os_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         cfg_q      <= '0;
         par_err_q  <= 1'b0;
         all_zero_q <= 1'b0;
      end else if (baud_tick_i) begin
         case (state_q)
            IDLE: begin
               if (start_det) begin
                  armed_q    <= 1'b0;
                  cfg_q      <= '{data_bits: cfg_data_bits_i, par_en: cfg_parity_en_i,
                                  par_even: cfg_parity_even_i, par_stick: cfg_parity_stick_i};
                  os_cnt_q   <= '0;
                  data_q     <= '0;
                  par_err_q  <= 1'b0;
                  all_zero_q <= 1'b1;
               end else if (rx_s) begin
                  armed_q <= 1'b1;
               end
            end
            START: begin
               if (os_cnt_q == OS_HALF) begin
                  os_cnt_q  <= '0;
                  bit_cnt_q <= '0;
               end else begin
                  os_cnt_q <= os_cnt_q + OS_W'(1);
               end
            end
            DATA: begin
               os_cnt_q <= os_cnt_q + OS_W'(1);
               if (os_cnt_q == OS_LAST) begin
                  data_q[bit_cnt_q] <= rx_s;
                  bit_cnt_q         <= bit_cnt_q + 3'd1;
                  if (rx_s) all_zero_q <= 1'b0;
               end
            end
            PARITY: begin
               os_cnt_q <= os_cnt_q + OS_W'(1);
               if (os_cnt_q == OS_LAST) begin
                  par_err_q <= par_err_now;
                  if (rx_s) all_zero_q <= 1'b0;
               end
            end
            STOP: begin
               os_cnt_q <= os_cnt_q + OS_W'(1);
            end
            default: os_cnt_q <= '0;
         endcase
      end
   end

   // Character-complete outputs: registered one clk after the stop sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_rx_o       <= '0;
         fifo_rx_push_o  <= 1'b0;
         rx_parity_err_o <= 1'b0;
         rx_frame_err_o  <= 1'b0;
         rx_break_o      <= 1'b0;
         rx_overrun_o    <= 1'b0;
      end else begin
         fifo_rx_push_o  <= 1'b0;
         rx_parity_err_o <= 1'b0;
         rx_frame_err_o  <= 1'b0;
         rx_break_o      <= 1'b0;
         rx_overrun_o    <= 1'b0;
         if (char_done) begin
            fifo_rx_o       <= data_q;
            fifo_rx_push_o  <= !fifo_rx_full_i;
            rx_overrun_o    <= fifo_rx_full_i;
            rx_parity_err_o <= cfg_q.par_en && par_err_q;
            rx_frame_err_o  <= !rx_s;
            rx_break_o      <= !rx_s && all_zero_q;
         end
      end
   end

   assign rx_busy_o = (state_q != IDLE);

`ifdef RX_TIMEOUT_EN
   logic [9:0]  to_cnt_q;
   logic [3:0]  char_bits;
   logic [15:0] to_thresh;

   // char_bits = start + N + parity + stop = 7 + data_bits + par_en.
   assign char_bits    = 4'd7 + {2'b00, cfg_q.data_bits} + {3'b000, cfg_q.par_en};
   assign to_thresh    = {12'd0, char_bits} * 16'(4 * OVERSAMPLE);
   assign rx_timeout_o = ({6'd0, to_cnt_q} >= to_thresh);

   // Idle-line tick counter; saturates rather than wrapping back to zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_q <= '0;
      end else if (start_det || fifo_rx_push_o || fifo_rx_pop_i || fifo_rx_empty_i) begin
         to_cnt_q <= '0;
      end else if (baud_tick_i && (state_q == IDLE) && (to_cnt_q != '1)) begin
         to_cnt_q <= to_cnt_q + 10'd1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frames plus random
// frames; a reference model predicts each character and a monitor compares.
module tb_uart_rx_deserializer;

   localparam int OS = 16;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
      logic       ovr;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       baud_tick = 1'b0;
   logic       rx = 1'b1;
   logic [1:0] cfg_db = 2'b11;
   logic       cfg_pe = 1'b0, cfg_pev = 1'b0, cfg_pst = 1'b0;
   logic       full = 1'b0;
   logic [7:0] fifo_rx;
   logic       push, perr, ferr, brk, ovr, busy;
`ifdef RX_TIMEOUT_EN
   logic       tmo;
`endif

   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];

   uart_rx_deserializer #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
      .clk               (clk),
      .reset             (reset),
      .baud_tick_i       (baud_tick),
      .rx_i              (rx),
      .cfg_data_bits_i   (cfg_db),
      .cfg_parity_en_i   (cfg_pe),
      .cfg_parity_even_i (cfg_pev),
      .cfg_parity_stick_i(cfg_pst),
      .fifo_rx_full_i    (full),
`ifdef RX_TIMEOUT_EN
      .fifo_rx_empty_i   (1'b1),
      .fifo_rx_pop_i     (1'b0),
      .rx_timeout_o      (tmo),
`endif
      .fifo_rx_o         (fifo_rx),
      .fifo_rx_push_o    (push),
      .rx_parity_err_o   (perr),
      .rx_frame_err_o    (ferr),
      .rx_break_o        (brk),
      .rx_overrun_o      (ovr),
      .rx_busy_o         (busy)
   );

   always #5 clk = ~clk;

   // Baud tick: one clk in four.
   initial begin
      int k = 0;
      forever begin
         @(negedge clk);
         k++;
         baud_tick = (k % 4 == 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Wait for n tick edges, then return at the following negedge.
   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!baud_tick) @(posedge clk);
      end
      @(negedge clk);
   endtask

   // Reference model + driver for one frame.
   task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic pe,
                             input logic pev, input logic pst, input logic flip,
                             input logic stop_bit, input logic full_v, input int idle);
      int         n;
      int         mask;
      int         ones;
      logic [7:0] dm;
      logic       p_ok, p;
      exp_t       e;
      n    = 5 + int'(db);
      mask = (1 << n) - 1;
      dm   = d & mask[7:0];
      ones = $countones(dm);
      if (pst)      p_ok = !pev;
      else if (pev) p_ok = (ones % 2 == 1);
      else          p_ok = (ones % 2 == 0);
      p = p_ok ^ flip;
      e.data = dm;
      e.perr = pe && (p != p_ok);
      e.ferr = !stop_bit;
      e.brk  = !stop_bit && (dm == 8'h00) && (!pe || !p);
      e.ovr  = full_v;
      exp_q.push_back(e);
      cfg_db = db; cfg_pe = pe; cfg_pev = pev; cfg_pst = pst;
      full = full_v;
      rx = 1'b0;
      wait_ticks(OS);
      // Config changes mid-frame must not affect this character.
      {cfg_db, cfg_pe, cfg_pev, cfg_pst} = 5'($urandom);
      for (int i = 0; i < n; i++) begin
         rx = dm[i];
         wait_ticks(OS);
      end
      if (pe) begin
         rx = p;
         wait_ticks(OS);
      end
      rx = stop_bit;
      wait_ticks(OS);
      rx = 1'b1;
      full = 1'b0;
      wait_ticks(idle);
   endtask

   // Monitor: pops the scoreboard whenever the DUT completes a character.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (push || ovr)) begin
            check("char_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("data",       32'(fifo_rx), 32'(e.data));
               check("push",       32'(push),    32'(!e.ovr));
               check("overrun",    32'(ovr),     32'(e.ovr));
               check("parity_err", 32'(perr),    32'(e.perr));
               check("frame_err",  32'(ferr),    32'(e.ferr));
               check("break",      32'(brk),     32'(e.brk));
            end
         end else if (!reset && (perr || ferr || brk)) begin
            check("stray_pulse", 32'({perr, ferr, brk}), 32'd0);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #900_000;
      $display("FAIL watchdog: run did not complete, %0d chars still pending", exp_q.size());
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      // Reset values.
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_data", 32'(fifo_rx), 32'd0);
      check("reset_push", 32'(push), 32'd0);
      reset = 1'b0;
      wait_ticks(4);

      // 8N1 0xA5; busy must be low once the stop bit has been sampled.
      send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      check("busy_after_stop", 32'(busy), 32'd0);
      wait_ticks(4);

      // 5E1 0x13: parity bit 0 is wrong, parity bit 1 is right.
      send_frame(8'h13, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4);
      send_frame(8'h13, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4);

      // Glitch shorter than half a bit: false start, no character.
      rx = 1'b0;
      wait_ticks(4);
      check("glitch_busy_high", 32'(busy), 32'd1);
      rx = 1'b1;
      wait_ticks(20);
      check("glitch_busy_low", 32'(busy), 32'd0);
      check("glitch_no_char", 32'(exp_q.size()), 32'd0);

      // Break: line low for two 8N1 character times, no retrigger while low.
      cfg_db = 2'b11; cfg_pe = 1'b0;
      exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1, ovr: 1'b0});
      rx = 1'b0;
      wait_ticks(200);
      check("break_busy_low", 32'(busy), 32'd0);
      wait_ticks(120);
      check("break_no_retrigger", 32'(busy), 32'd0);
      rx = 1'b1;
      wait_ticks(20);
      check("break_one_char", 32'(exp_q.size()), 32'd0);
      send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);

      // Overrun: FIFO full at char-complete.
      send_frame(8'h7E, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
      check("overrun_data_held", 32'(fifo_rx), 32'h7E);

      // Reset in the middle of a frame discards it.
      cfg_db = 2'b11; cfg_pe = 1'b0;
      rx = 1'b0;
      wait_ticks(OS);
      rx = 1'b1;
      wait_ticks(40);
      check("midframe_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("midframe_reset_busy", 32'(busy), 32'd0);
      check("midframe_reset_data", 32'(fifo_rx), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      wait_ticks(60);
      check("midframe_no_char", 32'(exp_q.size()), 32'd0);

      // Random frames across all configurations.
      for (int i = 0; i < 30; i++) begin
         logic [1:0] db;
         logic       pe, pev, pst;
         db  = 2'($urandom_range(0, 3));
         pe  = 1'($urandom_range(0, 1));
         pev = 1'($urandom_range(0, 1));
         pst = ($urandom_range(0, 3) == 0);
         send_frame(8'($urandom), db, pe, pev, pst, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                    $urandom_range(2, 12));
      end

      wait_ticks(40);
      check("all_chars_seen", 32'(exp_q.size()), 32'd0);
      check("final_busy", 32'(busy), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Serial receive front end of the APB UART; sits directly upstream of the RX FIFO.
- Oversamples the asynchronous rx line at 16x baud and detects and validates the start bit.
- Deserialises 5–8 data bits LSB-first, checks parity and stop, and pushes each completed character into the RX FIFO.
- Flags parity, framing, break and overrun conditions per character.

Parameters:
OVERSAMPLE, 16, baud_tick_i pulses per bit time; must be a power of 2, >= 8
SYNC_STAGES, 2, flops in the rx_i metastability synchroniser (>= 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
baud_tick_i  input  1  one-clk enable pulse at OVERSAMPLE x baud rate
rx_i  input  1  asynchronous serial line, idle high
cfg_data_bits_i  input  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity_en_i  input  1  parity bit present
cfg_parity_even_i  input  1  1=even, 0=odd
cfg_parity_stick_i  input  1  stick parity: expected bit = ~cfg_parity_even_i
fifo_rx_full_i  input  1  RX FIFO full
fifo_rx_o  output  8  received character, right-justified, unused upper bits 0
fifo_rx_push_o  output  1  one-clk push strobe
rx_parity_err_o  output  1  one-clk pulse, coincident with char-complete
rx_frame_err_o  output  1  one-clk pulse, stop bit sampled 0
rx_break_o  output  1  one-clk pulse, all bits including stop sampled 0
rx_overrun_o  output  1  one-clk pulse, char completed while FIFO full
rx_busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - synchroniser flops = 1; state = IDLE; all counters = 0.
  - fifo_rx_o = 0x00; all strobes/pulses = 0; rx_busy_o = 0.
- All sampling and counting advances only on clk edges where baud_tick_i = 1. Between ticks, state holds.
- os_cnt is log2(OVERSAMPLE) bits; bit_cnt is 3 bits.
- States:
  - IDLE: armed only after the synchronised line has been sampled high on at least one tick; the arm flag clears on every start detection.
    - When armed and a tick samples 0: latch all cfg_* inputs into a frame config, os_cnt = 0, go to START.
    - cfg_* changes mid-frame have no effect.
  - START: on the tick where os_cnt = OVERSAMPLE/2-1 (mid start bit), sample the line.
    - Sampled 1: false start, return to IDLE with no outputs.
    - Sampled 0: os_cnt = 0, bit_cnt = 0, go to DATA.
  - DATA: on the tick where os_cnt = OVERSAMPLE-1, sample, shift in LSB-first, bit_cnt += 1.
    - After N bits, go to PARITY if parity is enabled, else to STOP.
  - PARITY: sample at the same mid-bit point.
    - Error when even: XOR(data, p) != 0.
    - Error when odd: XOR(data, p) != 1.
    - Error when stick: p != ~even.
  - STOP: sample the first stop bit at its midpoint, then return to IDLE immediately (mid-stop resync).
    - Only one stop bit is checked, regardless of the line's configured stop-bit count.
- Char-complete (the clk after the stop sample):
  - fifo_rx_o is updated and held until the next char-complete.
  - If fifo_rx_full_i = 0: fifo_rx_push_o = 1 for one clk.
  - If fifo_rx_full_i = 1: no push, data dropped, rx_overrun_o = 1, fifo_rx_o still updated.
  - Error pulses are asserted in the same clk as the push/overrun.
- Break: data, parity (if enabled) and stop all 0 → rx_break_o and rx_frame_err_o both pulse.
  - The arm rule prevents re-triggering until the line returns high.
- Latency: from the stop-bit mid-sample tick to the push is exactly 1 clk.
- Reset asserted mid-frame: immediate return to IDLE; the partial character is discarded with no pulses.

Optional Feature:
- RX_TIMEOUT_EN defined:
  - Adds inputs fifo_rx_empty_i and fifo_rx_pop_i, and output rx_timeout_o (level).
  - A 10-bit tick counter increments in IDLE while fifo_rx_empty_i = 0.
  - rx_timeout_o = 1 once count >= 4 x char_bits x OVERSAMPLE, where char_bits = 1 + N + parity_en + 1, taken from the last frame config.
  - Counter and rx_timeout_o clear on start detect, push, fifo_rx_pop_i, or fifo_rx_empty_i = 1.
- Undefined: the ports and counter are absent; no timeout logic.

Test Plan:
- 8N1 frame, data 0xA5, FIFO not full → exactly one fifo_rx_push_o with fifo_rx_o = 0xA5; no error pulses; rx_busy_o low after the stop midpoint.
- 5E1, data 0x13, parity bit 0 → fifo_rx_o = 0x13, rx_parity_err_o = 1; repeat with parity bit 1 → no error.
- Glitch: rx_i low for 4 ticks then high → START aborts, no push, rx_busy_o returns to 0.
- Line held low for 2 char times in 8N1 → one push of 0x00 with rx_break_o = 1 and rx_frame_err_o = 1; no second character until the line goes high, then a new frame 0x3C is received correctly.
- fifo_rx_full_i = 1 during char-complete of 0x7E → no push, rx_overrun_o = 1, fifo_rx_o = 0x7E.
- RX_TIMEOUT_EN, 8N1, fifo_rx_empty_i = 0, line idle → rx_timeout_o rises after 640 ticks; a fifo_rx_pop_i pulse clears it.
